// File: rtl/demod_audio_out.sv
// Demodulator audio back end: source select, optional DC block, gain/saturate, show-ahead output FIFO.
// Optional feature macro: DEMOD_AUDIO_DC_BLOCK_EN enables the DC-tracking high-pass in stage 2.
module demod_audio_out #(
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DC_SHIFT   = 8,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk_in,
    input  logic                        RST,
    input  logic                        sample_valid,
    input  logic signed [IN_WIDTH-1:0]  FM_in,
    input  logic signed [IN_WIDTH-1:0]  PM_in,
    input  logic signed [IN_WIDTH-1:0]  AM_in,
    input  logic [1:0]                  mode,
    input  logic [3:0]                  gain_shift,
    output logic [OUT_WIDTH-1:0]        audio_data,
    output logic                        audio_valid,
    input  logic                        audio_ready,
    output logic [LW-1:0]               fifo_level,
    output logic                        overflow,
    input  logic                        overflow_clr
);

    typedef enum logic [1:0] {
        MODE_AM   = 2'b00,
        MODE_FM   = 2'b01,
        MODE_PM   = 2'b10,
        MODE_MUTE = 2'b11
    } mode_e;

    localparam int STAGES = 3;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int GW     = IN_WIDTH + 1 + 15;

    logic [STAGES:1] vld_pipe;

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) vld_pipe <= '0;
        else      vld_pipe <= {vld_pipe[STAGES-1:1], sample_valid};
    end

    // ---------------- stage 1: source select ----------------
    logic signed [IN_WIDTH-1:0] sel_x, s1_x;
    logic [1:0]                 s1_mode;

    always_comb begin
        sel_x = '0;
        case (mode_e'(mode))
            MODE_AM: sel_x = AM_in;
            MODE_FM: sel_x = FM_in;
            MODE_PM: sel_x = PM_in;
            default: sel_x = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            s1_x    <= '0;
            s1_mode <= '0;
        end else if (sample_valid) begin
            s1_x    <= sel_x;
            s1_mode <= mode;
        end
    end

    // ---------------- stage 2: DC block ----------------
    logic signed [IN_WIDTH:0] s2_y;
    logic [1:0]               s2_mode;

`ifdef DEMOD_AUDIO_DC_BLOCK_EN
    localparam int ACCW = IN_WIDTH + DC_SHIFT;

    logic signed [ACCW-1:0]   acc, acc_base, acc_nxt, dc_full;
    logic signed [IN_WIDTH:0] dc, y_dc;
    logic [1:0]               prev_mode;
    logic                     prev_seen;
    logic                     mode_chg;

    // The first sample after reset counts as a mode change so acc starts from zero.
    always_comb begin
        mode_chg = !prev_seen || (s1_mode != prev_mode);
        acc_base = mode_chg ? '0 : acc;
        dc_full  = acc_base >>> DC_SHIFT;
        dc       = dc_full[IN_WIDTH:0];
        y_dc     = $signed({s1_x[IN_WIDTH-1], s1_x}) - dc;
        acc_nxt  = acc_base + $signed({{(DC_SHIFT-1){y_dc[IN_WIDTH]}}, y_dc});
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            acc       <= '0;
            prev_mode <= '0;
            prev_seen <= 1'b0;
            s2_y      <= '0;
            s2_mode   <= '0;
        end else if (vld_pipe[1]) begin
            acc       <= acc_nxt;
            prev_mode <= s1_mode;
            prev_seen <= 1'b1;
            s2_y      <= y_dc;
            s2_mode   <= s1_mode;
        end
    end
`else
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            s2_y    <= '0;
            s2_mode <= '0;
        end else if (vld_pipe[1]) begin
            s2_y    <= {s1_x[IN_WIDTH-1], s1_x};
            s2_mode <= s1_mode;
        end
    end
`endif

    // ---------------- stage 3: gain and saturate ----------------
    logic signed [GW-1:0]  g_ext, g_shl, z;
    logic [OUT_WIDTH-1:0]  sat, s3_data;
    logic                  z_fits;

    always_comb begin
        g_ext  = {{15{s2_y[IN_WIDTH]}}, s2_y};
        g_shl  = g_ext <<< gain_shift;
        z      = g_shl >>> (IN_WIDTH - OUT_WIDTH);
        // z fits when every bit above the output sign bit matches it.
        z_fits = (&z[GW-1:OUT_WIDTH-1]) || !(|z[GW-1:OUT_WIDTH-1]);
        if (z_fits)     sat = z[OUT_WIDTH-1:0];
        else if (z[GW-1]) sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else            sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST)             s3_data <= '0;
        else if (vld_pipe[2]) s3_data <= (mode_e'(s2_mode) == MODE_MUTE) ? '0 : sat;
    end

    // ---------------- output FIFO ----------------
    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;
    logic [OUT_WIDTH-1:0] hold_q;
    logic                 full, pop, wr_en, drop;

    always_comb begin
        full  = (level == LW'(FIFO_DEPTH));
        pop   = (level != '0) && audio_ready;
        wr_en = vld_pipe[STAGES] && (!full || pop);
        drop  = vld_pipe[STAGES] && full && !pop;
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_ptr] <= s3_data;
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            hold_q   <= '0;
        end else begin
            hold_q <= audio_data;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // A drop wins over a clear in the same cycle.
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    assign audio_valid = (level != '0);
    assign audio_data  = audio_valid ? mem[rd_ptr] : hold_q;
    assign fifo_level  = level;

endmodule

// File: tb/tb_demod_audio_out.sv
// Directed bench for demod_audio_out; the DC-block section runs when DEMOD_AUDIO_DC_BLOCK_EN is defined.
module tb_demod_audio_out;

    logic        clk_in = 1'b0;
    logic        RST;
    logic        sample_valid;
    logic [23:0] FM_in, PM_in, AM_in;
    logic [1:0]  mode;
    logic [3:0]  gain_shift;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        audio_ready;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        overflow_clr;

    int checks = 0;
    int errors = 0;

    demod_audio_out dut (
        .clk_in(clk_in), .RST(RST), .sample_valid(sample_valid),
        .FM_in(FM_in), .PM_in(PM_in), .AM_in(AM_in), .mode(mode),
        .gain_shift(gain_shift), .audio_data(audio_data), .audio_valid(audio_valid),
        .audio_ready(audio_ready), .fifo_level(fifo_level), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One-cycle strobe; the non-selected inputs carry decoys.
    task automatic push(input logic [1:0] m, input logic [23:0] v);
        mode  = m;
        AM_in = 24'h7A0000;
        FM_in = 24'h5B0000;
        PM_in = 24'h3C0000;
        case (m)
            2'b00:   AM_in = v;
            2'b01:   FM_in = v;
            2'b10:   PM_in = v;
            default: ;
        endcase
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic pop();
        audio_ready = 1'b1;
        tick();
        audio_ready = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

`ifdef DEMOD_AUDIO_DC_BLOCK_EN
    int dc_cnt = 0, dc_nonmono = 0;
    logic signed [15:0] dc_first = 0, dc_prev = 0;

    task automatic dc_sample();
        if (audio_valid) begin
            if (dc_cnt == 0) dc_first = audio_data;
            else if ($signed(audio_data) > dc_prev) dc_nonmono++;
            dc_prev = audio_data;
            dc_cnt++;
        end
    endtask
`endif

    initial begin
        RST = 1'b0; sample_valid = 1'b0; FM_in = '0; PM_in = '0; AM_in = '0;
        mode = 2'b00; gain_shift = 4'd0; audio_ready = 1'b0; overflow_clr = 1'b0;
        #12;
        chk("rst_valid", audio_valid, 0);
        chk("rst_data", audio_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        tick();
        RST = 1'b1;
        tick();

`ifdef DEMOD_AUDIO_DC_BLOCK_EN
        audio_ready = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            push(2'b00, 24'h100000);
            dc_sample();
        end
        repeat (5) begin tick(); dc_sample(); end
        chk("dc_count", dc_cnt, 4096);
        chk("dc_first", 32'(dc_first), 32'h1000);
        chk("dc_monotonic", dc_nonmono, 0);
        chk("dc_final_small", (dc_prev >= -16'sd1 && dc_prev <= 16'sd1), 1);
        // mode change restarts the accumulator
        audio_ready = 1'b0;
        push(2'b01, 24'h100000);
        drain();
        chk("dc_modechg", audio_data, 16'h1000);
        pop();
        chk("dc_empty", fifo_level, 0);
`else
        // latency: strobe at N -> visible at N+4
        push(2'b01, 24'h010000);
        tick(); tick();
        chk("lat_n3_valid", audio_valid, 0);
        tick();
        chk("lat_n4_valid", audio_valid, 1);
        chk("lat_data", audio_data, 16'h0100);
        chk("lat_level", fifo_level, 1);
        pop();
        chk("lat_drained", fifo_level, 0);

        // source select and sign handling, gain 0
        push(2'b00, 24'hFFF000);
        push(2'b10, 24'h123456);
        push(2'b01, 24'hFFFF80);
        push(2'b11, 24'h123456);
        drain();
        chk("sel_level", fifo_level, 4);
        chk("sel_am", audio_data, 16'hFFF0); pop();
        chk("sel_pm", audio_data, 16'h1234); pop();
        chk("sel_fm_neg", audio_data, 16'hFFFF); pop();
        chk("sel_mute", audio_data, 16'h0000); pop();

        // gain and saturation
        gain_shift = 4'd4;
        push(2'b01, 24'h400000);
        push(2'b01, 24'hC00000);
        push(2'b01, 24'h010000);
        drain();
        gain_shift = 4'd15;
        push(2'b01, 24'h000001);
        drain();
        gain_shift = 4'd0;
        chk("gain_level", fifo_level, 4);
        chk("sat_pos", audio_data, 16'h7FFF); pop();
        chk("sat_neg", audio_data, 16'h8000); pop();
        chk("gain4", audio_data, 16'h1000); pop();
        chk("gain15", audio_data, 16'h0080); pop();

        // overflow: 10 strobes into 8 entries
        for (int i = 1; i <= 10; i++) push(2'b01, 24'(i) << 8);
        drain();
        chk("ovf_level", fifo_level, 8);
        chk("ovf_flag", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf_rd%0d", i), audio_data, i);
            pop();
        end
        chk("ovf_empty_level", fifo_level, 0);
        chk("ovf_empty_valid", audio_valid, 0);
        chk("hold_data", audio_data, 16'h0008);
        pop();
        chk("ready_empty_level", fifo_level, 0);
        chk("ovf_sticky", overflow, 1);
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // full with simultaneous write and pop
        for (int i = 0; i < 8; i++) push(2'b01, 24'(32'h20 + i) << 8);
        drain();
        chk("full_level", fifo_level, 8);
        push(2'b01, 24'h003000);
        tick(); tick();
        audio_ready = 1'b1; tick(); audio_ready = 1'b0;
        chk("full_wp_level", fifo_level, 8);
        chk("full_wp_ovf", overflow, 0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("full_rd%0d", i), audio_data, 32'h20 + i);
            pop();
        end
        chk("full_rd_new", audio_data, 16'h0030);
        pop();

        // mute enqueues zeros at the strobe rate
        push(2'b11, 24'h123456);
        push(2'b11, 24'h400000);
        push(2'b11, 24'h7FFFFF);
        drain();
        chk("mute_level", fifo_level, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mute_rd%0d", i), audio_data, 0);
            pop();
        end

        // clear and drop in the same cycle keeps overflow set
        for (int i = 1; i <= 8; i++) push(2'b01, 24'(i) << 8);
        drain();
        push(2'b01, 24'h00FF00);
        tick(); tick();
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        chk("clr_drop_ovf", overflow, 1);
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        chk("clr_only_ovf", overflow, 0);

        // reset with 5 queued and 2 in flight
        pop(); pop(); pop();
        chk("pre_rst_level", fifo_level, 5);
        push(2'b01, 24'h007700);
        push(2'b01, 24'h007800);
        RST = 1'b0;
        #1;
        chk("rst_mid_valid", audio_valid, 0);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_data", audio_data, 0);
        #3;
        RST = 1'b1;
        repeat (6) tick();
        chk("post_rst_valid", audio_valid, 0);
        chk("post_rst_level", fifo_level, 0);
        push(2'b01, 24'h050000);
        drain();
        chk("post_rst_data", audio_data, 16'h0500);
        chk("post_rst_one", fifo_level, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demod_audio_out.md
DEMOD_AUDIO_OUT -- requirements
Module: demod_audio_out

Interface
REQ-001 Parameter IN_WIDTH, default 24: width of each demodulator sample input.
REQ-002 Parameter OUT_WIDTH, default 16: width of the audio sample output.
REQ-003 Parameter FIFO_DEPTH, default 8: output FIFO entries; SHALL be a power of two, at least 2.
REQ-004 Parameter DC_SHIFT, default 8: DC-tracking time constant, 2^DC_SHIFT samples.
REQ-005 clk_in  input  1  sole clock; all state on rising edge.
REQ-006 RST  input  1  asynchronous, active-low reset.
REQ-007 sample_valid  input  1  one-cycle strobe; FM_in/PM_in/AM_in hold a new demodulated sample.
REQ-008 FM_in, PM_in, AM_in  input  IN_WIDTH each  signed two's-complement demodulator outputs.
REQ-009 mode  input  2  source select: 00 AM, 01 FM, 10 PM, 11 mute.
REQ-010 gain_shift  input  4  left-shift gain, 0..15.
REQ-011 audio_data  output  OUT_WIDTH  signed audio sample at FIFO head.
REQ-012 audio_valid  output  1  FIFO not empty.
REQ-013 audio_ready  input  1  DAC consumer accepts audio_data when audio_valid && audio_ready.
REQ-014 fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 overflow  output  1  sticky flag: a sample was dropped.
REQ-016 overflow_clr  input  1  synchronous clear of overflow.

Function
REQ-017 Stage 1: on sample_valid, register the input selected by mode (sampled the same cycle); mute registers zero.
REQ-018 Stage 2, DC block: accumulator acc is signed, IN_WIDTH+DC_SHIFT bits; dc = acc >>> DC_SHIFT; y = x - dc (IN_WIDTH+1 bits); acc <= acc + y; acc is updated only on valid samples.
REQ-019 A change of registered mode versus the previous valid sample clears acc to zero before that sample is processed.
REQ-020 Stage 3, gain/saturate: z = (y <<< gain_shift) >>> (IN_WIDTH-OUT_WIDTH), arithmetic; saturate z to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-021 Mute samples bypass gain and enter the FIFO as exact zero, preserving sample rate.
REQ-022 Latency: sample_valid at cycle N -> FIFO write at end of cycle N+3 -> audio_valid high at N+4 if the FIFO was empty.
REQ-023 Pipeline accepts a sample_valid every cycle; no back-pressure toward the demodulator.
REQ-024 FIFO is show-ahead: audio_data equals the oldest entry whenever audio_valid is high; audio_data holds its value while audio_valid is low.
REQ-025 Pop occurs on audio_valid && audio_ready; audio_ready while empty has no effect.
REQ-026 Full with write and no pop: the sample is dropped, contents unchanged, overflow set.
REQ-027 Full with simultaneous write and pop: both succeed; level unchanged; no overflow.
REQ-028 Empty with simultaneous write and audio_ready: write only; data visible next cycle.
REQ-029 Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
REQ-030 overflow_clr and a new drop in the same cycle: overflow remains set.

Reset
REQ-031 RST low asynchronously clears pipeline valids, stage registers, acc, pointers, fifo_level, overflow, and previous-mode register.
REQ-032 After reset: audio_valid=0, audio_data=0, fifo_level=0, overflow=0.
REQ-033 Reset mid-operation discards all in-flight and buffered samples; the first post-reset sample is treated as a mode change (acc starts at 0).

Configuration
REQ-034 Macro DEMOD_AUDIO_DC_BLOCK_EN: when defined, stage 2 is as in REQ-018/019; when undefined, stage 2 is a pure register (y = x, sign-extended), acc is not implemented, and latency stays 3 cycles to FIFO write.

Verification
REQ-035 mode=01, FM_in=24'h010000 constant, gain_shift=0, DC block off -> audio_data=16'h0100 per sample, 4 cycles after the first strobe.
REQ-036 DC block on, AM_in constant 24'h100000 for 4096 strobes -> output decays monotonically to magnitude <= 1.
REQ-037 FM_in=24'h400000, gain_shift=4 -> audio_data=16'h7FFF; FM_in=24'hC00000 -> 16'h8000.
REQ-038 audio_ready=0, 10 strobes, FIFO_DEPTH=8 -> fifo_level=8, overflow=1, first 8 samples read back in order; overflow_clr -> overflow=0.
REQ-039 FIFO full, strobe and audio_ready in the same cycle -> level stays 8, overflow stays 0; mode=11 -> zeros enqueued at the strobe rate.
REQ-040 RST pulsed low with 5 entries queued and 2 in flight -> audio_valid=0 immediately, and no stale sample appears after reset release.
